pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline; branches and jumps are resolved in MEM.
- Drives write-enable and flush (bubble) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Handles three hazard classes: load-use stalls, taken-branch/jump flushes and multi-cycle data-memory waits.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- MEM_TIMEOUT, 64, wait cycles in MEM_WAIT before MemTimeout is set.
- CNT_W, 32, width of the performance counters.

Ports:
- Clk  in  1  pipeline clock
- Reset  in  1  asynchronous, active-low reset
- IDRs  in  5  rs field of the instruction in ID
- IDRt  in  5  rt field of the instruction in ID
- IDUsesRt  in  1  instruction in ID reads rt
- EXmemread  in  1  instruction in EX is a load
- EXRegDst  in  5  destination register of the instruction in EX
- Mmemread  in  1  MEM-stage load
- Mmemwrite  in  1  MEM-stage store
- DMemReady  in  1  data memory completes the MEM access this cycle
- Mbranchtaken  in  1  taken branch, jump, jal or jalr resolved in MEM
- CountClear  in  1  synchronous clear of the counters and MemTimeout
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID enable
- IFIDFlush  out  1  IF/ID bubble
- IDEXWrite  out  1  ID/EX enable
- IDEXFlush  out  1  ID/EX bubble
- EXMEMWrite  out  1  EX/MEM enable
- EXMEMFlush  out  1  EX/MEM bubble
- MWBFlush  out  1  MEM/WB bubble (forces WBregwrite=0 and all WB controls to 0)
- StallCycles  out  CNT_W  count of stall cycles
- FlushEvents  out  CNT_W  count of branch flushes
- MemTimeout  out  1  sticky timeout flag

Behaviour:
- Control outputs are combinational from the state and the inputs. State, the wait counter, the perf counters and MemTimeout are registered.
- Reset (Reset=0, asynchronous):
  - state=RUN, wait counter=0, StallCycles=0, FlushEvents=0, MemTimeout=0.
  - While Reset is low, all write enables=0 and all flushes=1 so the pipeline is held empty.
- Default (no hazard): every *Write=1, every *Flush=0.
- Priority per cycle: memory wait > branch flush > load-use stall > normal.
- States: RUN, MEM_WAIT.
- Memory wait:
  - Condition: (Mmemread|Mmemwrite) & ~DMemReady, in either state.
  - Outputs: PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0 and MWBFlush=1. No other flush is asserted, and Mbranchtaken is ignored.
  - RUN->MEM_WAIT on this condition; the wait counter is cleared on entry.
  - MEM_WAIT->RUN on the cycle DMemReady=1. That cycle behaves as RUN: branch and load-use logic are evaluated normally.
  - A memory access that completes in 0 wait cycles (DMemReady=1 on its first cycle) never enters MEM_WAIT.
- Wait counter:
  - Increments each MEM_WAIT cycle and saturates at MEM_TIMEOUT.
  - When it reaches MEM_TIMEOUT, MemTimeout is set. The controller keeps waiting and does not abort.
- Branch flush (Mbranchtaken=1, no memory wait):
  - IFIDFlush=IDEXFlush=EXMEMFlush=1, PCWrite=1 (PC loads the target).
  - The MEM instruction itself proceeds: MWBFlush=0.
  - Load-use detection is suppressed because the ID instruction is squashed.
- Load-use stall:
  - Condition: EXmemread & EXRegDst!=0 & (EXRegDst==IDRs | (IDUsesRt & EXRegDst==IDRt)).
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXFlush=1.
  - Lasts exactly one cycle because the load advances out of EX.
- StallCycles: +1 on each memory-wait or load-use cycle.
- FlushEvents: +1 on each cycle where the branch flush is applied.
- Both counters saturate at all-ones.
- CountClear=1 zeroes both counters and MemTimeout next edge. It has priority over increments in the same cycle.
- Reset mid-wait: the state returns to RUN immediately and asynchronously.

Decomposition:
- Shared package holds:
  - the state encoding (RUN=1'b0, MEM_WAIT=1'b1);
  - the REG_ZERO constant (5'd0);
  - the default MEM_TIMEOUT.
- Natural sub-module: hazard_perf_counter, a saturating counter with increment and synchronous clear, instantiated twice.

Test Plan:
- Load-use: EXmemread=1, EXRegDst=8, IDRs=8 -> one cycle with PCWrite=0, IFIDWrite=0, IDEXFlush=1, StallCycles=1. Repeat with EXRegDst=0 -> no stall.
- Taken branch: Mbranchtaken=1 with a simultaneous load-use match -> IFIDFlush=IDEXFlush=EXMEMFlush=1, PCWrite=1, no stall, FlushEvents=1.
- Memory wait: Mmemread=1, DMemReady low for 3 cycles then high -> 3 cycles of all writes=0 and MWBFlush=1, back in RUN on cycle 4, StallCycles=3.
- Branch during wait: Mbranchtaken=1 with Mmemwrite=1, DMemReady=0 for 2 cycles, then DMemReady=1 -> no flush during the wait; flushes asserted only on the DMemReady cycle.
- Timeout: MEM_TIMEOUT=4, DMemReady held low for 6 cycles -> MemTimeout=1 after the 4th wait cycle, stays set after exit until CountClear.
- Reset mid-wait: Reset low during MEM_WAIT -> outputs immediately enables=0, flushes=1, counters=0; after release, state is RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM state encoding, the zero-register constant, the default
// parameter values and the packed control-bundle type.
package pipeline_hazard_ctrl_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned DEF_MEM_TIMEOUT = 64;
    localparam int unsigned DEF_CNT_W       = 32;

    // Pipeline-register and PC controls produced every cycle.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_write;
        logic exmem_flush;
        logic mwb_flush;
    } hazard_ctrl_t;

    // No-hazard controls: everything advances, nothing is squashed.
    function automatic hazard_ctrl_t ctrl_default();
        hazard_ctrl_t c;
        c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
              idex_write: 1'b1, idex_flush: 1'b0, exmem_write: 1'b1,
              exmem_flush: 1'b0, mwb_flush: 1'b0};
        return c;
    endfunction

    // Held-empty controls: nothing is written, every stage is bubbled.
    function automatic hazard_ctrl_t ctrl_hold_empty();
        hazard_ctrl_t c;
        c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
              idex_write: 1'b0, idex_flush: 1'b1, exmem_write: 1'b0,
              exmem_flush: 1'b1, mwb_flush: 1'b1};
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stall/flush controls and
// performance counters out.
//   master : pipeline side (drives stage status, receives controls)
//   slave  : controller side
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       IDRs;
    logic [4:0]       IDRt;
    logic             IDUsesRt;
    logic             EXmemread;
    logic [4:0]       EXRegDst;
    logic             Mmemread;
    logic             Mmemwrite;
    logic             DMemReady;
    logic             Mbranchtaken;
    logic             CountClear;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXWrite;
    logic             IDEXFlush;
    logic             EXMEMWrite;
    logic             EXMEMFlush;
    logic             MWBFlush;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushEvents;
    logic             MemTimeout;

    modport master (
        output IDRs, IDRt, IDUsesRt, EXmemread, EXRegDst, Mmemread, Mmemwrite,
               DMemReady, Mbranchtaken, CountClear,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite,
               EXMEMFlush, MWBFlush, StallCycles, FlushEvents, MemTimeout
    );

    modport slave (
        input  IDRs, IDRt, IDUsesRt, EXmemread, EXRegDst, Mmemread, Mmemwrite,
               DMemReady, Mbranchtaken, CountClear,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite,
               EXMEMFlush, MWBFlush, StallCycles, FlushEvents, MemTimeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count on the next edge
//   inc        : add one, holding at all-ones
//   count      : registered count
module hazard_perf_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline (branches resolve
// in MEM). Resolves memory waits, taken-branch flushes and load-use stalls,
// and keeps stall/flush counters plus a sticky memory-timeout flag.
//   Clk, Reset : clock, async active-low reset (pipeline held empty while low)
//   bus        : hazard status in, pipeline-register controls and counters out
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                  Clk,
    input  logic                  Reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned     WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              mem_timeout;
    logic              timeout_set;
    logic              mem_wait_c;
    logic              load_use_c;
    logic              stall_inc;
    logic              flush_inc;
    hazard_ctrl_t      ctrl;

    // Hazard detection from the current stage status.
    always_comb begin
        mem_wait_c = (bus.Mmemread | bus.Mmemwrite) & ~bus.DMemReady;
        load_use_c = bus.EXmemread & (bus.EXRegDst != REG_ZERO) &
                     ((bus.EXRegDst == bus.IDRs) |
                      (bus.IDUsesRt & (bus.EXRegDst == bus.IDRt)));
        stall_inc  = mem_wait_c | (load_use_c & ~bus.Mbranchtaken);
        flush_inc  = bus.Mbranchtaken & ~mem_wait_c;
    end

    // Next state, wait counter and pipeline controls.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ctrl         = ctrl_default();

        // The entering cycle is itself the first wait cycle, so the counter
        // restarts at one and reaches MEM_TIMEOUT on the MEM_TIMEOUT-th stall.
        case (state)
            ST_RUN: begin
                if (mem_wait_c) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_wait_c) begin
                    state_nxt = ST_RUN;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        if (!Reset) begin
            ctrl = ctrl_hold_empty();
        end else if (mem_wait_c) begin
            // Freeze everything upstream of MEM; let WB drain a bubble.
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.idex_write  = 1'b0;
            ctrl.exmem_write = 1'b0;
            ctrl.mwb_flush   = 1'b1;
        end else if (bus.Mbranchtaken) begin
            // Squash the three younger instructions; PC loads the target.
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
        end else if (load_use_c) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.idex_flush  = 1'b1;
        end
    end

    assign timeout_set = mem_wait_c & (wait_cnt_nxt == WAIT_MAX);

    // FSM, wait counter and sticky timeout flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (bus.CountClear) begin
                mem_timeout <= 1'b0;
            end else if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (bus.CountClear),
        .inc   (stall_inc),
        .count (bus.StallCycles)
    );

    hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (bus.CountClear),
        .inc   (flush_inc),
        .count (bus.FlushEvents)
    );

    assign bus.PCWrite    = ctrl.pc_write;
    assign bus.IFIDWrite  = ctrl.ifid_write;
    assign bus.IFIDFlush  = ctrl.ifid_flush;
    assign bus.IDEXWrite  = ctrl.idex_write;
    assign bus.IDEXFlush  = ctrl.idex_flush;
    assign bus.EXMEMWrite = ctrl.exmem_write;
    assign bus.EXMEMFlush = ctrl.exmem_flush;
    assign bus.MWBFlush   = ctrl.mwb_flush;
    assign bus.MemTimeout = mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// randomized stage status, compared each cycle against a rule-level model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 32;

    // Control vector order: PCWrite IFIDWrite IFIDFlush IDEXWrite IDEXFlush
    //                       EXMEMWrite EXMEMFlush MWBFlush
    localparam logic [7:0] V_HOLD   = 8'b0010_1011;
    localparam logic [7:0] V_NORM   = 8'b1101_0100;
    localparam logic [7:0] V_MWAIT  = 8'b0000_0001;
    localparam logic [7:0] V_BRANCH = 8'b1111_1110;
    localparam logic [7:0] V_LDUSE  = 8'b0001_1100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: length of the current run of waiting cycles, counters.
    int          m_run;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_flush;
    logic        m_to;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] dut_ctrl();
        return {bus.PCWrite, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXWrite,
                bus.IDEXFlush, bus.EXMEMWrite, bus.EXMEMFlush, bus.MWBFlush};
    endfunction

    function automatic logic m_memwait();
        return (bus.Mmemread || bus.Mmemwrite) && !bus.DMemReady;
    endfunction

    function automatic logic m_loaduse();
        return bus.EXmemread && (bus.EXRegDst != 5'd0) &&
               ((bus.EXRegDst == bus.IDRs) || (bus.IDUsesRt && (bus.EXRegDst == bus.IDRt)));
    endfunction

    // Priority: memory wait > branch > load-use > normal.
    function automatic logic [7:0] exp_ctrl();
        if (!reset)               return V_HOLD;
        if (m_memwait())          return V_MWAIT;
        if (bus.Mbranchtaken)     return V_BRANCH;
        if (m_loaduse())          return V_LDUSE;
        return V_NORM;
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic usesrt,
                         input logic exrd, input logic [4:0] dst, input logic rd,
                         input logic wr, input logic rdy, input logic br, input logic clr);
        bus.IDRs = rs;  bus.IDRt = rt;  bus.IDUsesRt = usesrt;
        bus.EXmemread = exrd;  bus.EXRegDst = dst;
        bus.Mmemread = rd;  bus.Mmemwrite = wr;  bus.DMemReady = rdy;
        bus.Mbranchtaken = br;  bus.CountClear = clr;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // One clock: check controls mid-cycle, advance model and check registers.
    task automatic cycle();
        logic mw, lu, br, clr;
        #2;
        check("ctrl", 64'(dut_ctrl()), 64'(exp_ctrl()));
        mw  = m_memwait();
        lu  = m_loaduse();
        br  = bus.Mbranchtaken;
        clr = bus.CountClear;
        @(posedge clk);
        #1;
        m_run = mw ? m_run + 1 : 0;
        if (clr) begin
            m_stall = '0;
            m_flush = '0;
            m_to    = 1'b0;
        end else begin
            if ((mw || (lu && !br)) && (m_stall != '1)) m_stall = m_stall + 1'b1;
            if (br && !mw && (m_flush != '1))           m_flush = m_flush + 1'b1;
            if (m_run >= T)                              m_to    = 1'b1;
        end
        check("stall_cycles", 64'(bus.StallCycles), 64'(m_stall));
        check("flush_events", 64'(bus.FlushEvents), 64'(m_flush));
        check("mem_timeout",  64'(bus.MemTimeout),  64'(m_to));
    endtask

    task automatic model_reset();
        m_run = 0;  m_stall = '0;  m_flush = '0;  m_to = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        model_reset();
        #1;
        check("reset_ctrl",  64'(dut_ctrl()), 64'(V_HOLD));
        check("reset_stall", 64'(bus.StallCycles), 64'd0);
        check("reset_flush", 64'(bus.FlushEvents), 64'd0);
        check("reset_to",    64'(bus.MemTimeout), 64'd0);
        @(posedge clk); @(posedge clk);
        #1;
        reset = 1'b1;
        idle(); cycle();

        // Load-use stall, then a zero-register destination that must not stall.
        drive(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        check("lu_stall_cnt", 64'(bus.StallCycles), 64'd1);
        idle(); cycle();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        check("lu_r0_cnt", 64'(bus.StallCycles), 64'd1);
        // rt match only counts when rt is read.
        drive(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        drive(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();

        // Taken branch beats a simultaneous load-use match.
        drive(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
        check("br_flush_cnt", 64'(bus.FlushEvents), 64'd1);
        check("br_stall_cnt", 64'(bus.StallCycles), 64'd2);

        // Load waits three cycles, completes on the fourth.
        repeat (3) begin
            drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        end
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        check("mw_stall_cnt", 64'(bus.StallCycles), 64'd5);
        check("mw_to", 64'(bus.MemTimeout), 64'd0);

        // Branch held during a store wait: flush only on the completing cycle.
        repeat (2) begin
            drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
        end
        check("bw_flush_cnt", 64'(bus.FlushEvents), 64'd1);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        check("bw_done_ctrl", 64'(dut_ctrl()), 64'(V_BRANCH));
        #0 cycle();
        check("bw_flush_cnt2", 64'(bus.FlushEvents), 64'd2);

        // Timeout after the T-th consecutive wait cycle, sticky until cleared.
        idle(); bus.CountClear = 1'b1; cycle();
        for (int i = 1; i <= 6; i++) begin
            drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
            check("to_step", 64'(bus.MemTimeout), 64'(i >= T));
        end
        idle(); cycle(); cycle();
        check("to_sticky", 64'(bus.MemTimeout), 64'd1);
        bus.CountClear = 1'b1; cycle();
        check("to_clear", 64'(bus.MemTimeout), 64'd0);
        check("clr_stall", 64'(bus.StallCycles), 64'd0);

        // Asynchronous reset in the middle of a wait.
        repeat (2) begin
            drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        end
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_ctrl",  64'(dut_ctrl()), 64'(V_HOLD));
        check("rst_mid_stall", 64'(bus.StallCycles), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        // A fresh wait must restart the timeout run from the first cycle.
        repeat (T - 1) begin
            drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        end
        check("rst_run_to", 64'(bus.MemTimeout), 64'd0);
        idle(); cycle();

        // Randomized stage status.
        for (int n = 0; n < 3000; n++) begin
            logic acc;
            acc = ($urandom_range(0, 1) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  acc & 1'($urandom_range(0, 1)), acc & 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 63) == 0));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
